// File: rtl/timer_bank.sv
// timer_bank: bank of independent count/compare timers sharing one tick.
// Define TIMER_PRESCALE_EN to build the shared prescaler; otherwise tick every cycle.
module timer_bank #(
   parameter int WIDTH          = 32,
   parameter int CHANNELS       = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [CHANNELS-1:0]         enable,
   input  logic [CHANNELS-1:0]         oneshot,
   input  logic [CHANNELS-1:0]         restart,
   input  logic [CHANNELS*WIDTH-1:0]   compare,
   input  logic [PRESCALE_WIDTH-1:0]   prescale,
   input  logic [CHANNELS-1:0]         irq_ack,
   output logic [CHANNELS*WIDTH-1:0]   count,
   output logic [CHANNELS-1:0]         match,
   output logic [CHANNELS-1:0]         irq,
   output logic [CHANNELS-1:0]         done
);

   logic tick;

`ifdef TIMER_PRESCALE_EN
   logic [PRESCALE_WIDTH-1:0] pre_cnt;

   // >= rather than == so a lowered prescale cannot strand the counter
   assign tick = (pre_cnt >= prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
      end
   end
`else
   logic unused_prescale;

   assign tick            = 1'b1;
   assign unused_prescale = ^prescale;
`endif

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [WIDTH-1:0] cnt;
      logic [WIDTH-1:0] cmp;
      logic [WIDTH-1:0] cmp_last;
      logic             adv;
      logic             wrap;
      logic             m_q;
      logic             irq_q;
      logic             done_q;

      assign cmp      = compare[i*WIDTH +: WIDTH];
      // compare of 0 behaves as 1: last value is 0 either way
      assign cmp_last = (cmp == '0) ? '0 : cmp - WIDTH'(1);
      assign adv      = tick & enable[i] & ~done_q & ~restart[i];
      assign wrap     = adv & (cnt >= cmp_last);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt    <= '0;
            m_q    <= 1'b0;
            irq_q  <= 1'b0;
            done_q <= 1'b0;
         end else begin
            m_q   <= wrap;
            irq_q <= wrap | (irq_q & ~irq_ack[i]);
            if (restart[i]) begin
               cnt    <= '0;
               done_q <= 1'b0;
            end else if (wrap) begin
               cnt    <= '0;
               done_q <= oneshot[i];
            end else if (adv) begin
               cnt <= cnt + WIDTH'(1);
            end
         end
      end

      assign count[i*WIDTH +: WIDTH] = cnt;
      assign match[i]                = m_q;
      assign irq[i]                  = irq_q;
      assign done[i]                 = done_q;
   end

endmodule

// File: tb/tb_timer_bank.sv
// tb_timer_bank: directed vector table, corner sequences and a randomized
// run checked against a cycle-level behavioural model of the timer bank.
module tb_timer_bank;

   localparam int W  = 8;
   localparam int CH = 4;
   localparam int PW = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [CH-1:0]   enable = '0;
   logic [CH-1:0]   oneshot = '0;
   logic [CH-1:0]   restart = '0;
   logic [CH*W-1:0] compare = '0;
   logic [PW-1:0]   prescale = '0;
   logic [CH-1:0]   irq_ack = '0;
   logic [CH*W-1:0] count;
   logic [CH-1:0]   match;
   logic [CH-1:0]   irq;
   logic [CH-1:0]   done;

   int tests = 0;
   int fails = 0;

   timer_bank #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .oneshot(oneshot),
      .restart(restart), .compare(compare), .prescale(prescale),
      .irq_ack(irq_ack), .count(count), .match(match), .irq(irq),
      .done(done)
   );

   always #5 clk = ~clk;

   // behavioural model: plain integers per channel
   int mc[CH];
   bit mm[CH];
   bit mi[CH];
   bit md[CH];
   int pc = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            pc = 0;
            for (int i = 0; i < CH; i++) begin
               mc[i] = 0; mm[i] = 0; mi[i] = 0; md[i] = 0;
            end
         end else begin
            bit tk;
`ifdef TIMER_PRESCALE_EN
            tk = (pc >= int'(prescale));
            pc = tk ? 0 : pc + 1;
`else
            tk = 1'b1;
`endif
            for (int i = 0; i < CH; i++) begin
               int per;
               bit wr;
               per = int'(compare[i*W +: W]);
               if (per == 0) per = 1;
               wr = 1'b0;
               if (restart[i]) begin
                  mc[i] = 0;
                  md[i] = 0;
               end else if (tk && enable[i] && !md[i]) begin
                  if (mc[i] + 1 >= per) begin
                     mc[i] = 0;
                     wr = 1'b1;
                     if (oneshot[i]) md[i] = 1'b1;
                  end else begin
                     mc[i] = mc[i] + 1;
                  end
               end
               mm[i] = wr;
               mi[i] = wr ? 1'b1 : (irq_ack[i] ? 1'b0 : mi[i]);
            end
         end
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int cnt_of(input int ch);
      return int'(count[ch*W +: W]);
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   typedef struct {
      int ch;
      int cmp;
      bit os;
      int n;
      int exp_cnt;
      int exp_matches;
      bit exp_done;
   } vec_t;

   vec_t vt[10];

   task automatic run_vec(input vec_t v, input int idx);
      int m;
      m = 0;
      restart[v.ch] = 1'b1;
      enable[v.ch]  = 1'b1;
      oneshot[v.ch] = v.os;
      compare[v.ch*W +: W] = W'(v.cmp);
      step(1);
      restart[v.ch] = 1'b0;
      repeat (v.n) begin
         step(1);
         if (match[v.ch]) m++;
      end
      chk($sformatf("vec%0d_count", idx), cnt_of(v.ch), v.exp_cnt);
      chk($sformatf("vec%0d_matches", idx), m, v.exp_matches);
      chk($sformatf("vec%0d_done", idx), done[v.ch], v.exp_done);
      enable[v.ch]  = 1'b0;
      oneshot[v.ch] = 1'b0;
   endtask

   initial begin
      int exp_seq[4];
      int m;
      int chg;
      int prev;

      vt[0] = '{0, 4,   1'b0, 6,  2, 1, 1'b0};
      vt[1] = '{0, 4,   1'b0, 8,  0, 2, 1'b0};
      vt[2] = '{3, 0,   1'b0, 5,  0, 5, 1'b0};
      vt[3] = '{3, 1,   1'b0, 3,  0, 3, 1'b0};
      vt[4] = '{2, 5,   1'b1, 5,  0, 1, 1'b1};
      vt[5] = '{2, 5,   1'b1, 12, 0, 1, 1'b1};
      vt[6] = '{2, 5,   1'b1, 2,  2, 0, 1'b0};
      vt[7] = '{1, 7,   1'b0, 13, 6, 1, 1'b0};
      vt[8] = '{1, 2,   1'b0, 7,  1, 3, 1'b0};
      vt[9] = '{0, 255, 1'b0, 3,  3, 0, 1'b0};

      #3;
      chk("reset_count", count, 0);
      chk("reset_match", match, 0);
      chk("reset_irq", irq, 0);
      chk("reset_done", done, 0);
      step(2);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vt[i], i);

      // periodic sequence, sticky irq, ack
      irq_ack = '1;
      step(1);
      irq_ack = '0;
      chk("irq_cleared", irq, 0);
      exp_seq = '{1, 2, 3, 0};
      restart[0] = 1'b1; enable[0] = 1'b1;
      compare[0 +: W] = W'(4);
      step(1);
      restart[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step(1);
         chk($sformatf("per_count%0d", k), cnt_of(0), exp_seq[k]);
         chk($sformatf("per_match%0d", k), match[0], (k == 3) ? 1 : 0);
      end
      enable[0] = 1'b0;
      step(3);
      chk("irq_sticky", irq[0], 1);
      chk("match_one_cycle", match[0], 0);
      irq_ack[0] = 1'b1;
      step(1);
      irq_ack[0] = 1'b0;
      chk("irq_ack_clear", irq[0], 0);

      // compare shrink below current count, then wrap coincident with ack
      restart[3] = 1'b1; enable[3] = 1'b1;
      compare[3*W +: W] = W'(20);
      step(1);
      restart[3] = 1'b0;
      step(10);
      chk("shrink_pre", cnt_of(3), 10);
      compare[3*W +: W] = W'(4);
      step(1);
      chk("shrink_count", cnt_of(3), 0);
      chk("shrink_match", match[3], 1);
      chk("shrink_irq", irq[3], 1);
      compare[3*W +: W] = W'(0);
      irq_ack[3] = 1'b1;
      step(1);
      chk("ack_wrap_irq", irq[3], 1);
      chk("ack_wrap_match", match[3], 1);
      enable[3] = 1'b0;
      step(1);
      irq_ack[3] = 1'b0;
      chk("ack_after_irq", irq[3], 0);

      // prescaler
      prescale = PW'(2);
      step(5);
      restart[1] = 1'b1; enable[1] = 1'b1;
      compare[1*W +: W] = W'(3);
      step(1);
      restart[1] = 1'b0;
      m = 0; chg = 0; prev = 0;
      repeat (18) begin
         step(1);
         if (match[1]) m++;
         if (cnt_of(1) != prev) chg++;
         prev = cnt_of(1);
      end
`ifdef TIMER_PRESCALE_EN
      chk("pre_advances", chg, 6);
      chk("pre_matches", m, 2);
`else
      chk("pre_advances", chg, 18);
      chk("pre_matches", m, 6);
`endif
      enable[1] = 1'b0;
      prescale  = '0;
      step(3);

      // asynchronous reset mid-operation
      restart[0] = 1'b1; enable[0] = 1'b1;
      compare[0 +: W] = W'(1);
      step(1);
      restart[0] = 1'b0;
      step(1);
      compare[0 +: W] = W'(20);
      step(7);
      chk("mid_count", cnt_of(0), 7);
      chk("mid_irq", irq[0], 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_count", count, 0);
      chk("async_irq", irq, 0);
      chk("async_match", match, 0);
      chk("async_done", done, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk("post_reset_count", cnt_of(0), 1);
      enable[0] = 1'b0;
      step(1);

      // randomized run against the model
      for (int i = 0; i < CH; i++) compare[i*W +: W] = W'($urandom_range(0, 9));
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic [CH*W-1:0] ec;
         logic [CH-1:0]   em;
         logic [CH-1:0]   ei;
         logic [CH-1:0]   ed;
         for (int i = 0; i < CH; i++) begin
            ec[i*W +: W] = W'(mc[i]);
            em[i] = mm[i];
            ei[i] = mi[i];
            ed[i] = md[i];
         end
         chk($sformatf("rnd%0d_count", cyc), count, ec);
         chk($sformatf("rnd%0d_match", cyc), match, em);
         chk($sformatf("rnd%0d_irq", cyc), irq, ei);
         chk($sformatf("rnd%0d_done", cyc), done, ed);
         for (int i = 0; i < CH; i++) begin
            enable[i]  = ($urandom_range(0, 9) < 8);
            restart[i] = ($urandom_range(0, 99) < 3);
            oneshot[i] = ($urandom_range(0, 9) == 0);
            irq_ack[i] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 19) == 0)
               compare[i*W +: W] = W'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 99) == 0) prescale = PW'($urandom_range(0, 3));
         step(1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter and compare width per channel (>=2).
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent timer channels (>=1).
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 8: width of the shared prescaler.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port enable  input  CHANNELS  per-channel run level.
REQ-007 SHALL have port oneshot  input  CHANNELS  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-008 SHALL have port restart  input  CHANNELS  per-channel synchronous clear of count and done.
REQ-009 SHALL have port compare  input  CHANNELS*WIDTH  per-channel period; channel i at bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port prescale  input  PRESCALE_WIDTH  shared divider; tick every prescale+1 cycles.
REQ-011 SHALL have port irq_ack  input  CHANNELS  per-channel clear of sticky irq.
REQ-012 SHALL have port count  output  CHANNELS*WIDTH  per-channel current count, same packing as compare.
REQ-013 SHALL have port match  output  CHANNELS  per-channel one-cycle wrap pulse.
REQ-014 SHALL have port irq  output  CHANNELS  per-channel sticky wrap flag.
REQ-015 SHALL have port done  output  CHANNELS  per-channel one-shot-expired flag.

Function
REQ-016 SHALL generate a shared tick: prescaler counter increments every cycle; at value >= prescale it returns to 0 and tick is asserted that cycle; prescale=0 gives tick every cycle.
REQ-017 SHALL advance channel i only on cycles with tick=1, enable[i]=1, done[i]=0, restart[i]=0; otherwise count[i] holds.
REQ-018 SHALL, on an advancing cycle, load count[i] with 0 if count[i] >= compare[i]-1, else count[i]+1, all arithmetic in WIDTH bits.
REQ-019 SHALL treat compare[i]=0 as compare[i]=1 (count stays 0, wraps on every advancing cycle).
REQ-020 SHALL assert match[i] for exactly the one cycle following each edge at which the wrap of REQ-018 occurs.
REQ-021 SHALL set irq[i] on the wrap edge; irq_ack[i] clears it on the next edge; simultaneous wrap and ack leaves irq[i]=1.
REQ-022 SHALL, in one-shot mode, set done[i] on the wrap edge with count[i]=0; channel then frozen until restart[i].
REQ-023 SHALL, on restart[i]=1, set count[i]=0 and done[i]=0 on the next edge, with priority over any advance; no match or irq from that cycle.
REQ-024 SHALL apply a compare[i] change on the next advancing cycle; count[i] >= new compare[i]-1 wraps immediately.
REQ-025 SHALL sample oneshot[i] on the wrap edge only; changing it mid-period affects only that period's end.
REQ-026 SHALL keep channels fully independent except for the shared tick.

Reset
REQ-027 SHALL, while rst_n=0, force all count, match, irq, done outputs and the prescaler counter to 0, independent of clk.
REQ-028 SHALL, after rst_n deassert, have the first possible tick on the first rising edge (prescaler starts at 0).

Configuration
REQ-029 SHALL compile the prescaler in when TIMER_PRESCALE_EN is defined, behaving per REQ-016.
REQ-030 SHALL, when TIMER_PRESCALE_EN is undefined, omit prescaler logic, tick constantly 1, prescale port present but ignored.

Verification
REQ-031 SHALL cover periodic: CHANNELS=4, prescale=0, compare[0]=4, enable[0]=1 -> count[0] 0,1,2,3,0,...; match[0] pulse every 4 cycles; irq[0] sticks until irq_ack[0].
REQ-032 SHALL cover prescaler (TIMER_PRESCALE_EN defined): prescale=2, compare[1]=3 -> count[1] increments every 3 cycles, match[1] every 9; undefined build -> every cycle, every 3.
REQ-033 SHALL cover one-shot: oneshot[2]=1, compare[2]=5 -> single match[2] after 5 advances, done[2]=1, count[2] holds 0; restart[2] -> done[2]=0, counting resumes.
REQ-034 SHALL cover boundaries: compare[3]=0 -> match[3] every tick; count[3]=10 then compare[3]=4 -> wrap to 0 on next advance; wrap coincident with irq_ack[3] -> irq[3] stays 1.
REQ-035 SHALL cover reset mid-operation: rst_n low asynchronously while count[0]=7, irq[0]=1 -> all outputs 0 immediately, counting restarts from 0 after release.
